divider32: RTL and testbench
============================

# divider32

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the subtract-based counterpart to the combinational carry-lookahead adder: one 33-bit trial subtraction per clock, restoring algorithm. The execute stage issues an operation with a single-cycle `start` pulse, stalls on `busy`, and captures `result` when `done` pulses.

## Interface
- No parameters. Width is fixed at 32.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Operation request. Sampled only in IDLE.
- `op`  in  2  Equals funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend`  in  32  rs1 value, sampled with `start`.
- `divisor`  in  32  rs2 value, sampled with `start`.
- `flush`  in  1  Pipeline kill. Aborts any operation in flight.
- `busy`  out  1  High while an operation is accepted and not yet done.
- `done`  out  1  One-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  Quotient (DIV/DIVU) or remainder (REM/REMU). Held until the next `done`.

## Operation
- Reset: state = IDLE, `busy`=0, `done`=0, `result`=0, and all internal registers are cleared. Reset is asynchronous, so assertion mid-operation aborts the operation immediately and no `done` is produced.
- States: IDLE, CALC, FINISH.
- IDLE with `start`=1 and `flush`=0:
  - Latch `op`, both operand signs, and the magnitudes. For signed ops the magnitude is the two's complement when the sign bit is set; 0x80000000 maps to unsigned 0x80000000. For unsigned ops the sign bits are forced to 0.
  - Special cases go directly to FINISH with a preset result:
    - Divisor = 0: quotient = 0xFFFFFFFF, remainder = dividend.
    - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - All other cases: go to CALC with count = 0, rem = 0, q = dividend magnitude.
- CALC, one iteration per cycle:
  - trial = {rem, q[31]} − {1'b0, dmag}, computed at 33 bits.
  - If trial[32]=0: rem = trial[31:0] and the quotient bit shifted in is 1.
  - Otherwise: rem = {rem[30:0], q[31]} and the bit shifted in is 0.
  - q shifts left by one each iteration.
  - After 32 iterations (count = 31), go to FINISH.
- FINISH:
  - Negate the quotient when qsign = sa ^ sb.
  - Negate the remainder when sa.
  - Select the quotient or remainder by op[1], register it into `result`, pulse `done`, and return to IDLE.
- `start` while busy is ignored: no queueing and no effect on the running operation.
- `flush`=1 in any state: next state is IDLE, `busy` drops, no `done` is produced, and `result` keeps its previous value. `flush` takes priority over `start` in the same cycle.

## Timing
- Normal operation: `start` sampled at edge N.
  - `busy`=1 after edge N.
  - CALC occupies edges N+1..N+32.
  - FINISH registers the result at edge N+33.
  - `done`=1 and `busy`=0 for the cycle after edge N+33.
  - Latency from `start` to `done` is 33 cycles.
- Special cases: FINISH at edge N+1, so `done` arrives after 1 cycle.
- `busy` and `done` are never both high.
- A new `start` is accepted in the same cycle that `done` is high, because the state is already IDLE. Back-to-back issue period is 34 cycles.
- Operands must not need to stay stable after the `start` edge; the block captures everything it needs at that edge.

## Test plan
- DIVU 100 / 7: `done` exactly 33 cycles after `start`, `result` = 14. REMU with the same operands gives 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). REM 7 / −2 → 1.
- DIVU 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. Both deliver `done` 1 cycle after `start`.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, 1 cycle. REM with the same operands → 0. DIVU with the same operands → 0 after 33 cycles.
- DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF. A second `start` asserted while busy is ignored and `result` is unchanged.
- `flush` at cycle 10 of CALC: no `done`, `busy` low the next cycle. `rst_n` low mid-CALC: all outputs are 0 immediately. A subsequent DIVU 9 / 3 returns 3.

Source files
------------

// File: rtl/divider32.sv
// divider32 -- multi-cycle 32-bit integer divider for RV32M DIV/DIVU/REM/REMU.
// Restoring algorithm. Each clock does one 33-bit trial subtraction. A
// single-cycle start pulse in IDLE launches an operation. Divide-by-zero and
// signed overflow skip the iteration and finish after one cycle.
//
// Handshake: start is honoured only in IDLE and only when flush is low.
// busy is high from the accepting edge until the operation finishes. done
// pulses for one cycle with result valid, and busy is already low in that
// cycle. result holds its value until the next done. flush aborts any
// operation in flight without producing done.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   operation request (sampled in IDLE)
//   op         in   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend   in   rs1 value, captured with start
//   divisor    in   rs2 value, captured with start
//   flush      in   pipeline kill, beats start
//   busy       out  operation accepted and not yet done
//   done       out  one-cycle result-valid pulse
//   result     out  quotient or remainder, held between dones
//   state_dbg  out  current FSM state (0 IDLE, 1 CALC, 2 FINISH)
module divider32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      state_q;
    logic        rem_sel_q;   // op[1]: 1 selects the remainder
    logic        sa_q;        // dividend sign
    logic        sb_q;        // divisor sign
    logic [31:0] dmag_q;      // divisor magnitude
    logic [31:0] rem_q;       // partial remainder
    logic [31:0] q_q;         // dividend bits shifting out, quotient bits shifting in
    logic [4:0]  count_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;

    // Operand decode for the accepting cycle. Unsigned ops force the signs to 0.
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        sgn_ovf;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[31];
    assign b_neg     = is_signed & divisor[31];
    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign a_mag     = a_neg ? (~dividend + 32'd1) : dividend;
    assign b_mag     = b_neg ? (~divisor + 32'd1) : divisor;
    assign div_zero  = (divisor == 32'd0);
    assign sgn_ovf   = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

    // One restoring step. A non-negative trial means the divisor fits.
    logic [32:0] trial;
    assign trial = {rem_q, q_q[31]} - {1'b0, dmag_q};

    // Sign fix-up and selection used in FINISH.
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;
    logic [31:0] result_d;
    assign quo_fin  = (sa_q ^ sb_q) ? (~q_q + 32'd1) : q_q;
    assign rem_fin  = sa_q ? (~rem_q + 32'd1) : rem_q;
    assign result_d = rem_sel_q ? rem_fin : quo_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_sel_q <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dmag_q    <= 32'd0;
            rem_q     <= 32'd0;
            q_q       <= 32'd0;
            count_q   <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            rem_sel_q <= op[1];
                            dmag_q    <= b_mag;
                            count_q   <= 5'd0;
                            busy_q    <= 1'b1;
                            if (div_zero) begin
                                // Preset results are already final, so the
                                // signs are cleared to keep FINISH from negating.
                                sa_q    <= 1'b0;
                                sb_q    <= 1'b0;
                                q_q     <= 32'hFFFF_FFFF;
                                rem_q   <= dividend;
                                state_q <= S_FINISH;
                            end else if (sgn_ovf) begin
                                sa_q    <= 1'b0;
                                sb_q    <= 1'b0;
                                q_q     <= 32'h8000_0000;
                                rem_q   <= 32'd0;
                                state_q <= S_FINISH;
                            end else begin
                                sa_q    <= a_neg;
                                sb_q    <= b_neg;
                                q_q     <= a_mag;
                                rem_q   <= 32'd0;
                                state_q <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        if (!trial[32]) begin
                            rem_q <= trial[31:0];
                        end else begin
                            rem_q <= {rem_q[30:0], q_q[31]};
                        end
                        q_q     <= {q_q[30:0], ~trial[32]};
                        count_q <= count_q + 5'd1;
                        if (count_q == 5'd31) begin
                            state_q <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_divider32.sv
`timescale 1ns/1ps
module tb_divider32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  divider32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  longint      t_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_exp = 32'd0;

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output int lat);
    logic [31:0] qv;
    logic [31:0] rv;
    bit          sgn;
    sgn = !o[0];
    lat = 33;
    if (b == 32'd0) begin
      qv  = 32'hFFFF_FFFF;
      rv  = a;
      lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      qv  = 32'h8000_0000;
      rv  = 32'd0;
      lat = 1;
    end else if (sgn) begin
      qv = $signed(a) / $signed(b);
      rv = $signed(a) % $signed(b);
    end else begin
      qv = a / b;
      rv = a % b;
    end
    r = o[1] ? rv : qv;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy && done) begin
        n_err++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: result 0x%08h with no operation pending", result);
        end else begin
          logic [31:0] e;
          int          l;
          longint      t;
          int          got_lat;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          t = t_q.pop_front();
          got_lat = int'(($time - t - 5) / 10);
          check("result", result, e);
          check("latency", got_lat, l);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns 1ns after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    logic [31:0] r;
    int          lat;
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    if (track) begin
      ref_model(o, a, b, r, lat);
      exp_q.push_back(r);
      lat_q.push_back(lat);
      t_q.push_back($time);
      last_exp = r;
    end
    #1;
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Leaves the caller at the negedge where done is seen.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within 60 cycles");
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b, 1'b1);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    dividend = 32'd0;
    divisor  = 32'd0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases; each new issue starts on the negedge where done is high.
    run(OP_DIVU, 32'd100, 32'd7);
    run(OP_REMU, 32'd100, 32'd7);
    run(OP_DIV,  32'hFFFF_FFF9, 32'd2);
    run(OP_REM,  32'hFFFF_FFF9, 32'd2);
    run(OP_REM,  32'd7, 32'hFFFF_FFFE);
    run(OP_DIVU, 32'd5, 32'd0);
    run(OP_REM,  32'd5, 32'd0);
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start while busy must be ignored.
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1);
    repeat (5) @(negedge clk);
    start    = 1'b1;
    op       = OP_REMU;
    dividend = 32'd123;
    divisor  = 32'd4;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Flush partway through CALC: no done, busy drops, result held.
    issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("busy_after_flush", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("result_held_after_flush", result, last_exp);

    // Asynchronous reset mid-CALC clears outputs immediately.
    issue(OP_DIVU, 32'd77777, 32'd5, 1'b0);
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    last_exp = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(OP_DIVU, 32'd9, 32'd3);

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: b = a;
        default: b = $urandom;
      endcase
      run(o, a, b);
    end

    // Drain any pending expectation.
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
